dot_product_scheduler: RTL
==========================

DOT_PRODUCT_SCHEDULER -- requirements
Module: dot_product_scheduler

Interface
REQ-001 The block SHALL have parameter NO_REQ, default 4, giving the number of requesters sharing one dot-product unit.
REQ-002 The block SHALL have parameter element_width, default 32, giving the result width.
REQ-003 The block SHALL have parameter no_of_units, default 256, giving the dot-product unit lane count.
REQ-004 The block SHALL have parameter CLEAR_CYCLES, default 2, giving the unit-reset pulse length in cycles.
REQ-005 The block SHALL have parameter TIMEOUT, default 4096, giving the maximum WAIT cycles per job.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 req  input  NO_REQ  per-requester job request, level, held until that requester's done.
REQ-009 req_total  input  32*NO_REQ  per-requester element count; requester i occupies bits [32*i+31:32*i].
REQ-010 grant  output  NO_REQ  one-hot owner of the unit; all zero when idle.
REQ-011 dp_reset  output  1  active-high synchronous reset to the dot-product unit.
REQ-012 dp_read_now  output  1  single-cycle launch pulse to the unit's outsider_read_now.
REQ-013 dp_total  output  32  element count to the unit's total input.
REQ-014 dp_finish  input  1  unit finish flag; sticky until dp_reset.
REQ-015 dp_result  input  element_width  unit dot-product output.
REQ-016 done  output  NO_REQ  one-hot, one-cycle completion pulse.
REQ-017 result  output  element_width  result register, valid while done is nonzero and held afterwards.
REQ-018 job_err  output  1  one-cycle pulse coincident with done when the job was rejected or timed out.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 timeout_err  output  1  sticky flag; cleared only by reset.

Function
REQ-021 The FSM SHALL have exactly these states: IDLE, CLEAR, LAUNCH, WAIT, DONE.
REQ-022 IDLE: when any req bit is high, the block SHALL select the first set bit searching upward (with wrap) from the round-robin pointer.
REQ-023 IDLE: the block SHALL register grant and dp_total from the selected requester and go to CLEAR on the next edge.
REQ-024 Rotation: the round-robin pointer SHALL move to (granted index + 1) mod NO_REQ when the job enters DONE.
REQ-025 Rejection: if the selected req_total is 0 or not a multiple of no_of_units, the block SHALL go from IDLE directly to DONE with job_err=1.
REQ-026 Rejection: a rejected job SHALL NOT assert dp_reset or dp_read_now.
REQ-027 CLEAR: dp_reset SHALL be 1 for exactly CLEAR_CYCLES cycles, then the block SHALL go to LAUNCH.
REQ-028 LAUNCH: dp_read_now SHALL be 1 for exactly one cycle, then the block SHALL go to WAIT.
REQ-029 WAIT: the block SHALL count cycles from 0.
REQ-030 WAIT: when dp_finish=1, the block SHALL capture dp_result into result and go to DONE.
REQ-031 WAIT: when the count reaches TIMEOUT without dp_finish, the block SHALL set timeout_err, leave result unchanged, assert job_err, and go to DONE.
REQ-032 DONE: done[granted]=1 for one cycle; grant SHALL clear and the block SHALL return to IDLE on the following edge.
REQ-033 A new job SHALL NOT be granted in the DONE cycle.
REQ-034 Outside CLEAR, dp_reset SHALL be 0 (except during reset, see REQ-040).
REQ-035 Outside LAUNCH, dp_read_now SHALL be 0.
REQ-036 grant and dp_total SHALL stay stable from CLEAR through DONE.
REQ-037 req_total changes after the grant SHALL be ignored.
REQ-038 Deassertion of the granted req mid-job SHALL be ignored: the job completes and done still pulses.
REQ-039 Simultaneous requests SHALL be resolved only by the round-robin pointer; a continuously requesting client SHALL be served within NO_REQ jobs.

Reset
REQ-040 While reset=0: state=IDLE, pointer=0, grant=0, done=0, dp_read_now=0, dp_total=0, result=0, job_err=0, busy=0, timeout_err=0, and dp_reset=1 so the unit is held in reset.
REQ-041 Reset asserted mid-job SHALL abort the job immediately with no done pulse.
REQ-042 After release, the first job SHALL begin with a full CLEAR phase.

Verification
REQ-043 req=0001, total=512; model asserts dp_finish 20 cycles after dp_read_now with result 0x40490FDB -> dp_reset 2 cycles, one dp_read_now, done=0001 with result=0x40490FDB, job_err=0.
REQ-044 req=1111 held, all totals=256 -> grants in order 0001,0010,0100,1000,0001; no grant is issued during DONE.
REQ-045 req=0010 with total=300, then total=0 -> done=0010 with job_err=1 each time; dp_read_now and dp_reset never pulse.
REQ-046 TIMEOUT=64, model never finishes -> done plus job_err at WAIT count 64; timeout_err stays 1 through later successful jobs.
REQ-047 reset driven low during WAIT -> all outputs take their reset values asynchronously; no done; after release, req=0100 is served with a fresh CLEAR.
REQ-048 Granted req dropped in WAIT -> job still completes and done pulses.

Source files
------------

// File: rtl/dot_product_scheduler_if.sv
// Bus between the scheduler and one shared dot-product unit.
// The scheduler drives reset/launch/total; the unit answers with finish/result.
interface dot_product_scheduler_if #(
    parameter int element_width = 32
);
    logic                     dp_reset;
    logic                     dp_read_now;
    logic [31:0]              dp_total;
    logic                     dp_finish;
    logic [element_width-1:0] dp_result;

    modport master (
        output dp_reset, dp_read_now, dp_total,
        input  dp_finish, dp_result
    );

    modport slave (
        input  dp_reset, dp_read_now, dp_total,
        output dp_finish, dp_result
    );
endinterface

// File: rtl/dot_product_scheduler.sv
// Round-robin scheduler sharing one dot-product unit among NO_REQ requesters:
// arbitrate, clear the unit, launch it, wait for finish or timeout, report done.
module dot_product_scheduler #(
    parameter int NO_REQ        = 4,
    parameter int element_width = 32,
    parameter int no_of_units   = 256,
    parameter int CLEAR_CYCLES  = 2,
    parameter int TIMEOUT       = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NO_REQ-1:0]        req,
    input  logic [32*NO_REQ-1:0]     req_total,
    output logic [NO_REQ-1:0]        grant,
    output logic [NO_REQ-1:0]        done,
    output logic [element_width-1:0] result,
    output logic                     job_err,
    output logic                     busy,
    output logic                     timeout_err,
    dot_product_scheduler_if.master  dp
);

    localparam int PTR_W   = (NO_REQ > 1) ? $clog2(NO_REQ) : 1;
    localparam int CNT_MAX = (TIMEOUT > CLEAR_CYCLES) ? TIMEOUT : CLEAR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, DONE} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [CNT_W-1:0]   cnt;

    logic               sel_valid;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   idx;
    logic [NO_REQ-1:0]  sel_onehot;
    logic [31:0]        sel_total;
    logic               sel_bad;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] i);
        return PTR_W'((int'(i) + 1) % NO_REQ);
    endfunction

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        // Scan downward in offset so the set bit nearest the pointer is the last one kept.
        for (int k = NO_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NO_REQ);
            if (req[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = idx;
            end
        end
        sel_onehot = NO_REQ'(1) << sel_idx;
        sel_total  = req_total[32*sel_idx +: 32];
        sel_bad    = (sel_total == 32'd0) || ((sel_total % 32'(no_of_units)) != 32'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            ptr            <= '0;
            gnt_idx        <= '0;
            cnt            <= '0;
            grant          <= '0;
            done           <= '0;
            result         <= '0;
            job_err        <= 1'b0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
            dp.dp_reset    <= 1'b1;
            dp.dp_read_now <= 1'b0;
            dp.dp_total    <= '0;
        end else begin
            done    <= '0;
            job_err <= 1'b0;
            case (state)
                IDLE: begin
                    dp.dp_reset <= 1'b0;
                    if (sel_valid) begin
                        grant       <= sel_onehot;
                        gnt_idx     <= sel_idx;
                        dp.dp_total <= sel_total;
                        busy        <= 1'b1;
                        if (sel_bad) begin
                            // Rejected job never touches the unit.
                            done    <= sel_onehot;
                            job_err <= 1'b1;
                            ptr     <= next_ptr(sel_idx);
                            state   <= DONE;
                        end else begin
                            dp.dp_reset <= 1'b1;
                            cnt         <= '0;
                            state       <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    if (cnt == CLEAR_LAST) begin
                        dp.dp_reset    <= 1'b0;
                        dp.dp_read_now <= 1'b1;
                        state          <= LAUNCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LAUNCH: begin
                    dp.dp_read_now <= 1'b0;
                    cnt            <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (dp.dp_finish) begin
                        result <= dp.dp_result;
                        done   <= grant;
                        ptr    <= next_ptr(gnt_idx);
                        state  <= DONE;
                    end else if (cnt == WAIT_LAST) begin
                        // Timed out: result keeps its previous value.
                        timeout_err <= 1'b1;
                        job_err     <= 1'b1;
                        done        <= grant;
                        ptr         <= next_ptr(gnt_idx);
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
